// File: rtl/pi_link_pkg.sv
// Shared Pi link definitions: word and block geometry plus link FSM states.
// Used by the 16->512 receive assembler and the 512->16 transmit side.
package pi_link_pkg;
   localparam int WORD_W  = 16;
   localparam int WORDS   = 32;
   localparam int BLOCK_W = WORD_W * WORDS;
   localparam int CNT_W   = 6;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      HOLD,
      ABORT
   } link_state_t;
endpackage

// File: rtl/gpio_strobe_sync.sv
// Synchronises an async strobe and its data bus into clk; emits rise pulse.
// Ports: clk, reset_n (sync, active-low), strobe/data in; data_sync, rise out.
module gpio_strobe_sync #(
   parameter int W      = 16,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         strobe,
   input  logic [0:W-1] data,
   output logic [0:W-1] data_sync,
   output logic         rise
);
   logic [STAGES-1:0] s_q;
   logic [0:W-1]      d_q [STAGES];
   logic              prev;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s_q  <= '0;
         prev <= 1'b0;
         for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
      end else begin
         s_q    <= {s_q[STAGES-2:0], strobe};
         prev   <= s_q[STAGES-1];
         d_q[0] <= data;
         for (int i = 1; i < STAGES; i++) d_q[i] <= d_q[i-1];
      end
   end

   assign data_sync = d_q[STAGES-1];
   assign rise      = s_q[STAGES-1] & ~prev;
endmodule

// File: rtl/pi_gpio_assembler.sv
// Packs 16-bit Pi GPIO words into a 512-bit block for the SHA3-512 core.
// Ports: Pi side pi_data/pi_strobe/pi_ack; control go/kill; block512 with
// block_valid/block_ready handshake; word_count, overrun, done status.
// Option PI_RX_PARITY_EN adds pi_parity input and sticky parity_err output.
module pi_gpio_assembler #(
   parameter int WORD_W      = 16,
   parameter int WORDS       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [0:WORD_W-1]       pi_data,
   input  logic                    pi_strobe,
   output logic                    pi_ack,
`ifdef PI_RX_PARITY_EN
   input  logic                    pi_parity,
   output logic                    parity_err,
`endif
   input  logic                    go,
   input  logic                    kill,
   output logic [0:WORD_W*WORDS-1] block512,
   output logic                    block_valid,
   input  logic                    block_ready,
   output logic [5:0]              word_count,
   output logic                    overrun,
   output logic                    done
);
   import pi_link_pkg::*;

   link_state_t       state, state_n;
   logic [5:0]        count_n;
   logic              ack_n, ovr_n, done_n, we;
   logic              rise;
   logic [0:WORD_W-1] word_s;

`ifdef PI_RX_PARITY_EN
   // Parity bit rides the same sync chain so it lines up with its word.
   localparam int SW = WORD_W + 1;
   logic [0:SW-1] bus_in, bus_s;
   logic          par_ok;
   logic          perr_n, par_abort, pab_n;
   assign bus_in = {pi_parity, pi_data};
   assign word_s = bus_s[1:SW-1];
   assign par_ok = ~^bus_s;
`else
   localparam int SW = WORD_W;
   logic [0:SW-1] bus_in, bus_s;
   assign bus_in = pi_data;
   assign word_s = bus_s;
`endif

   gpio_strobe_sync #(
      .W      (SW),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .strobe    (pi_strobe),
      .data      (bus_in),
      .data_sync (bus_s),
      .rise      (rise)
   );

   assign block_valid = (state == HOLD);

   always_comb begin
      state_n = state;
      count_n = word_count;
      ack_n   = pi_ack;
      ovr_n   = overrun;
      done_n  = 1'b0;
      we      = 1'b0;
`ifdef PI_RX_PARITY_EN
      perr_n  = parity_err;
      pab_n   = par_abort;
`endif
      unique case (state)
         IDLE: begin
            if (go) begin
               state_n = COLLECT;
               count_n = '0;
            end
         end
         COLLECT: begin
            if (kill) begin
               state_n = ABORT;
               count_n = '0;
`ifdef PI_RX_PARITY_EN
               pab_n   = 1'b0;
`endif
            end else if (rise) begin
`ifdef PI_RX_PARITY_EN
               if (!par_ok) begin
                  state_n = ABORT;
                  count_n = '0;
                  perr_n  = 1'b1;
                  pab_n   = 1'b1;
               end else
`endif
               begin
                  we      = 1'b1;
                  count_n = word_count + 6'd1;
                  ack_n   = ~pi_ack;
                  if (word_count == 6'(WORDS - 1)) state_n = HOLD;
               end
            end
         end
         HOLD: begin
            if (kill) begin
               state_n = ABORT;
               count_n = '0;
`ifdef PI_RX_PARITY_EN
               pab_n   = 1'b0;
`endif
            end else if (block_ready) begin
               state_n = IDLE;
               count_n = '0;
               done_n  = 1'b1;
            end else if (rise) begin
               ovr_n = 1'b1;
            end
         end
         ABORT: begin
            count_n = '0;
`ifdef PI_RX_PARITY_EN
            // A parity abort waits for a fresh go; a kill abort for kill low.
            if (par_abort) begin
               if (go) begin
                  state_n = COLLECT;
                  pab_n   = 1'b0;
               end
            end else if (!kill) begin
               state_n = IDLE;
            end
`else
            if (!kill) state_n = IDLE;
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         word_count <= '0;
         pi_ack     <= 1'b0;
         overrun    <= 1'b0;
         done       <= 1'b0;
         block512   <= '0;
`ifdef PI_RX_PARITY_EN
         parity_err <= 1'b0;
         par_abort  <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         word_count <= count_n;
         pi_ack     <= ack_n;
         overrun    <= ovr_n;
         done       <= done_n;
`ifdef PI_RX_PARITY_EN
         parity_err <= perr_n;
         par_abort  <= pab_n;
`endif
         if (we) block512[int'(word_count) * WORD_W +: WORD_W] <= word_s;
      end
   end
endmodule
